// File: rtl/fcvt_pkg.sv
// Shared types and constants for the integer-to-single-precision converter.
// Holds the rounding-mode and FSM state encodings used by int2float_seq and fcvt_round.
package fcvt_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rm_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        NORM  = 2'b01,
        ROUND = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [7:0] EXP_BIAS = 8'd127;
    // Biased exponent of an operand whose leading one already sits in bit 31.
    localparam logic [7:0] EXP_INIT = 8'd158;

endpackage

// File: rtl/int2float_seq_if.sv
// Operand/result handshake bundle for int2float_seq.
// The master side supplies operands and consumes results; the slave is the converter.
interface int2float_seq_if;

    logic        valid_in;
    logic        ready_in;
    logic [31:0] int_in;
    logic        is_unsigned;
    logic [2:0]  rm;
    logic        kill;
    logic        valid_out;
    logic        ready_out;
    logic [31:0] result;
    logic        fflag_nx;

    modport master (
        output valid_in, int_in, is_unsigned, rm, kill, ready_out,
        input  ready_in, valid_out, result, fflag_nx
    );

    modport slave (
        input  valid_in, int_in, is_unsigned, rm, kill, ready_out,
        output ready_in, valid_out, result, fflag_nx
    );

endinterface

// File: rtl/fcvt_round.sv
// Combinational rounding stage: takes a normalised magnitude (leading one in bit 31,
// passed without it) and produces the packed single-precision result and inexact flag.
module fcvt_round
    import fcvt_pkg::*;
(
    input  logic [30:0] i_mag,
    input  logic        i_sign,
    input  logic [7:0]  i_exp,
    input  logic [2:0]  i_rm,
    output logic [31:0] o_result,
    output logic        o_nx
);

    logic [22:0] w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic        w_inc;
    logic [23:0] w_mantInc;
    logic [7:0]  w_expOut;

    always_comb begin
        w_mant   = i_mag[30:8];
        w_guard  = i_mag[7];
        w_sticky = |i_mag[6:0];

        // Encodings 101-111 are reserved and fall back to round-to-nearest-even.
        case (rm_t'(i_rm))
            RTZ:     w_inc = 1'b0;
            RDN:     w_inc = i_sign & (w_guard | w_sticky);
            RUP:     w_inc = ~i_sign & (w_guard | w_sticky);
            RMM:     w_inc = w_guard;
            default: w_inc = w_guard & (w_sticky | w_mant[0]);
        endcase

        w_mantInc = {1'b0, w_mant} + {23'd0, w_inc};
        w_expOut  = w_mantInc[23] ? (i_exp + 8'd1) : i_exp;

        o_result = {i_sign, w_expOut, (w_mantInc[23] ? 23'd0 : w_mantInc[22:0])};
        o_nx     = w_guard | w_sticky;
    end

endmodule

// File: rtl/int2float_seq.sv
// Multi-cycle FCVT.S.W / FCVT.S.WU converter: capture, normalise, round, hold result.
// Define FCVT_UNSIGNED_EN to honour is_unsigned; otherwise every operand is signed.
module int2float_seq
    import fcvt_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    int2float_seq_if.slave bus
);

    state_t      r_state;
    logic [31:0] r_mag;
    logic [7:0]  r_exp;
    logic        r_sign;
    logic [2:0]  r_rm;
    logic        r_valid;
    logic [31:0] r_result;
    logic        r_nx;

    logic        w_isUnsigned;
    logic        w_sign;
    logic [31:0] w_mag;
    logic [31:0] w_roundResult;
    logic        w_roundNx;

`ifdef FCVT_UNSIGNED_EN
    assign w_isUnsigned = bus.is_unsigned;
`else
    assign w_isUnsigned = 1'b0;
`endif

    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    assign w_sign = ~w_isUnsigned & bus.int_in[31];
    assign w_mag  = w_sign ? (~bus.int_in + 32'd1) : bus.int_in;

    assign bus.ready_in  = (r_state == IDLE);
    assign bus.valid_out = r_valid;
    assign bus.result    = r_result;
    assign bus.fflag_nx  = r_nx;

    fcvt_round u_round (
        .i_mag    (r_mag[30:0]),
        .i_sign   (r_sign),
        .i_exp    (r_exp),
        .i_rm     (r_rm),
        .o_result (w_roundResult),
        .o_nx     (w_roundNx)
    );

    // kill outranks every other transition, including a pending DONE handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_mag    <= 32'd0;
            r_exp    <= 8'd0;
            r_sign   <= 1'b0;
            r_rm     <= 3'd0;
            r_valid  <= 1'b0;
            r_result <= 32'd0;
            r_nx     <= 1'b0;
        end else if (bus.kill) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.valid_in) begin
                        r_sign  <= w_sign;
                        r_mag   <= w_mag;
                        r_exp   <= EXP_INIT;
                        r_rm    <= bus.rm;
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    if (r_mag == 32'd0) begin
                        r_result <= 32'd0;
                        r_nx     <= 1'b0;
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end else if (r_mag[31]) begin
                        r_state <= ROUND;
                    end else if (r_mag[31:24] == 8'd0) begin
                        r_mag <= {r_mag[23:0], 8'd0};
                        r_exp <= r_exp - 8'd8;
                    end else begin
                        r_mag <= {r_mag[30:0], 1'b0};
                        r_exp <= r_exp - 8'd1;
                    end
                end
                ROUND: begin
                    r_result <= w_roundResult;
                    r_nx     <= w_roundNx;
                    r_valid  <= 1'b1;
                    r_state  <= DONE;
                end
                DONE: begin
                    if (bus.ready_out) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int2float_seq.sv
// Self-checking bench for int2float_seq: a float-conversion reference model feeds a
// scoreboard that is compared against the DUT on every cycle valid_out is high.
module tb_int2float_seq;
    import fcvt_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        nx;
    } expect_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    expect_t expQ[$];

    int2float_seq_if ifc ();

    int2float_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Reference conversion: locate the leading one, keep 24 significant bits, round the rest.
    function automatic expect_t modelConvert(input logic [31:0] v, input bit uns, input logic [2:0] rmv);
        expect_t     e;
        bit          sign;
        bit          inc;
        bit          inexact;
        logic [63:0] mag;
        logic [63:0] keep;
        logic [63:0] rem;
        logic [63:0] half;
        int          p;
        int          shift;
`ifdef FCVT_UNSIGNED_EN
        sign = !uns && v[31];
`else
        sign = v[31];
        if (uns) sign = v[31];
`endif
        mag = sign ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
        if (mag == 64'd0) begin
            e.res = 32'd0;
            e.nx  = 1'b0;
            return e;
        end
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        if (p <= 23) begin
            keep = mag << (23 - p);
            rem  = 64'd0;
            half = 64'd1;
        end else begin
            shift = p - 23;
            keep  = mag >> shift;
            rem   = mag & ((64'd1 << shift) - 64'd1);
            half  = 64'd1 << (shift - 1);
        end
        inexact = (rem != 64'd0);
        case (rmv)
            3'd1:    inc = 1'b0;
            3'd2:    inc = sign && inexact;
            3'd3:    inc = !sign && inexact;
            3'd4:    inc = inexact && (rem >= half);
            default: inc = inexact && ((rem > half) || ((rem == half) && keep[0]));
        endcase
        keep = keep + {63'd0, inc};
        if (keep[24]) begin
            keep = keep >> 1;
            p++;
        end
        e.res = {sign, 8'(p + 127), keep[22:0]};
        e.nx  = inexact;
        return e;
    endfunction

    // Scoreboard compare: every cycle valid_out is high it must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && ifc.valid_out === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL spurious_valid_out actual=1 expected=0");
            end else begin
                checkOutput("result", ifc.result, expQ[0].res);
                checkOutput("fflag_nx", {31'd0, ifc.fflag_nx}, {31'd0, expQ[0].nx});
                if (ifc.ready_out && !ifc.kill) void'(expQ.pop_front());
            end
        end
    end

    task automatic waitReady();
        int n = 0;
        while (ifc.ready_in !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (ifc.ready_in !== 1'b1) checkOutput("ready_in_timeout", {31'd0, ifc.ready_in}, 32'd1);
    endtask

    // Drive one operand, measure latency (accept cycle counts as 1), hold, then hand off.
    task automatic applyStimulus(input logic [31:0] v, input bit uns, input logic [2:0] rmv,
                                 input int expLat, input int holdCycles);
        int lat;
        waitReady();
        ifc.valid_in    = 1'b1;
        ifc.int_in      = v;
        ifc.is_unsigned = uns;
        ifc.rm          = rmv;
        expQ.push_back(modelConvert(v, uns, rmv));
        @(posedge clk); #1;
        ifc.valid_in = 1'b0;
        lat = 1;
        while (ifc.valid_out !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (ifc.valid_out !== 1'b1) begin
            checkOutput("valid_out_timeout", {31'd0, ifc.valid_out}, 32'd1);
            expQ.delete();
            return;
        end
        if (expLat > 0) checkOutput("latency", lat, expLat);
        else            checkOutput("latency_bound", {31'd0, (lat <= 13)}, 32'd1);
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            checkOutput("hold_valid_out", {31'd0, ifc.valid_out}, 32'd1);
        end
        ifc.ready_out = 1'b1;
        @(posedge clk); #1;
        ifc.ready_out = 1'b0;
        checkOutput("post_handshake_ready_in", {31'd0, ifc.ready_in}, 32'd1);
        checkOutput("post_handshake_valid_out", {31'd0, ifc.valid_out}, 32'd0);
    endtask

    // Start converting 1, then abort in the third NORM cycle with kill or reset.
    task automatic abortScenario(input bit useReset);
        waitReady();
        ifc.valid_in    = 1'b1;
        ifc.int_in      = 32'h0000_0001;
        ifc.is_unsigned = 1'b0;
        ifc.rm          = RNE;
        @(posedge clk); #1;
        ifc.valid_in = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        if (useReset) begin
            reset = 1'b1;
            #1;
            checkOutput("reset_abort_ready_in", {31'd0, ifc.ready_in}, 32'd1);
            checkOutput("reset_abort_valid_out", {31'd0, ifc.valid_out}, 32'd0);
            @(posedge clk); #1;
            reset = 1'b0;
        end else begin
            ifc.kill = 1'b1;
            @(posedge clk); #1;
            ifc.kill = 1'b0;
            checkOutput("kill_ready_in", {31'd0, ifc.ready_in}, 32'd1);
            checkOutput("kill_valid_out", {31'd0, ifc.valid_out}, 32'd0);
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic pinModel(input string name, input logic [31:0] v, input bit uns,
                            input logic [2:0] rmv, input logic [31:0] res, input logic nx);
        expect_t e;
        e = modelConvert(v, uns, rmv);
        checkOutput({name, "_res"}, e.res, res);
        checkOutput({name, "_nx"}, {31'd0, e.nx}, {31'd0, nx});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] vals [5];
        vals = '{32'h1234_5678, 32'hFFFF_FF9C, 32'h00FF_FFFF, 32'hFEDC_BA98, 32'h7FFF_FFC0};

        reset           = 1'b1;
        ifc.valid_in    = 1'b0;
        ifc.int_in      = 32'd0;
        ifc.is_unsigned = 1'b0;
        ifc.rm          = 3'd0;
        ifc.kill        = 1'b0;
        ifc.ready_out   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid_out", {31'd0, ifc.valid_out}, 32'd0);
        checkOutput("reset_result", ifc.result, 32'd0);
        checkOutput("reset_fflag_nx", {31'd0, ifc.fflag_nx}, 32'd0);
        checkOutput("reset_ready_in", {31'd0, ifc.ready_in}, 32'd1);
        reset = 1'b0;

        pinModel("model_one", 32'h0000_0001, 1'b0, RNE, 32'h3F80_0000, 1'b0);
        pinModel("model_minus_one", 32'hFFFF_FFFF, 1'b0, RNE, 32'hBF80_0000, 1'b0);
        pinModel("model_max_rne", 32'h7FFF_FFFF, 1'b0, RNE, 32'h4F00_0000, 1'b1);
        pinModel("model_max_rtz", 32'h7FFF_FFFF, 1'b0, RTZ, 32'h4EFF_FFFF, 1'b1);
        pinModel("model_tie_rne", 32'h0100_0001, 1'b0, RNE, 32'h4B80_0000, 1'b1);
        pinModel("model_tie_rup", 32'h0100_0001, 1'b0, RUP, 32'h4B80_0001, 1'b1);
        pinModel("model_tie_rmm", 32'h0100_0001, 1'b0, RMM, 32'h4B80_0001, 1'b1);
        pinModel("model_min_int", 32'h8000_0000, 1'b0, RNE, 32'hCF00_0000, 1'b0);

        applyStimulus(32'h0000_0001, 1'b0, RNE, 13, 0);
        applyStimulus(32'hFFFF_FFFF, 1'b0, RNE, 13, 0);
        applyStimulus(32'h7FFF_FFFF, 1'b0, RNE, 0, 0);
        applyStimulus(32'h7FFF_FFFF, 1'b0, RTZ, 0, 0);
        applyStimulus(32'h0100_0001, 1'b0, RNE, 0, 0);
        applyStimulus(32'h0100_0001, 1'b0, RUP, 0, 0);
        applyStimulus(32'h0100_0001, 1'b0, RMM, 0, 0);
        applyStimulus(32'h8000_0000, 1'b0, RNE, 3, 0);
        applyStimulus(32'h8000_0000, 1'b1, RNE, 3, 0);
        applyStimulus(32'hFFFF_FFFF, 1'b1, RUP, 0, 0);
        applyStimulus(32'h0000_0000, 1'b0, RNE, 2, 5);

        for (int v = 0; v < 5; v++)
            for (int r = 0; r < 8; r++)
                applyStimulus(vals[v], 1'b0, 3'(r), 0, v % 2);

        abortScenario(1'b0);
        applyStimulus(32'h0000_0001, 1'b0, RNE, 13, 0);
        abortScenario(1'b1);
        applyStimulus(32'h0000_0001, 1'b0, RNE, 13, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int2float_seq.md
INT2FLOAT_SEQ -- requirements
Module: int2float_seq

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: valid_in  input  1  operand valid.
REQ-004 SHALL have port: ready_in  output  1  high only in IDLE.
REQ-005 SHALL have port: int_in  input  32  integer operand (FCVT.S.W / FCVT.S.WU source).
REQ-006 SHALL have port: is_unsigned  input  1  1 = treat int_in as unsigned; sampled with the operand.
REQ-007 SHALL have port: rm  input  3  rounding mode; sampled with the operand.
REQ-008 SHALL have port: kill  input  1  pipeline flush.
REQ-009 SHALL have port: valid_out  output  1  result valid.
REQ-010 SHALL have port: ready_out  input  1  consumer accepts result.
REQ-011 SHALL have port: result  output  32  IEEE-754 single.
REQ-012 SHALL have port: fflag_nx  output  1  inexact flag.

Function
REQ-013 SHALL use states IDLE, NORM, ROUND, DONE.
REQ-014 IDLE: on valid_in && ready_in, SHALL capture the operand: sign = !is_unsigned && int_in[31]; mag = sign ? two's-complement negation of int_in : int_in (32-bit unsigned, so 0x80000000 stays 0x80000000); exp = 158; rm latched; go to NORM.
REQ-015 NORM, one action per cycle: mag==0 -> DONE with result 0x00000000, nx 0; mag[31]==1 -> ROUND; mag[31:24]==0 -> mag<<=8, exp-=8; otherwise -> mag<<=1, exp-=1.
REQ-016 ROUND (one cycle): mant = mag[30:8], G = mag[7], S = |mag[6:0].
REQ-017 ROUND: increment by rm: 000 RNE (G && (S || mant[0])); 001 RTZ (never); 010 RDN (sign && (G||S)); 011 RUP (!sign && (G||S)); 100 RMM (G); 101-111 SHALL behave as RNE.
REQ-018 ROUND: a mant carry-out SHALL set mant = 0 and exp += 1.
REQ-019 ROUND: SHALL register result = {sign, exp, mant} and nx = G||S, then go to DONE.
REQ-020 DONE: valid_out SHALL be high; result/fflag_nx SHALL be held stable while ready_out is low; on ready_out, return to IDLE.
REQ-021 Latency from accept edge to valid_out: 2 cycles for zero; 3 for |value| with bit31 set; 13 worst case (magnitude 1); never more than 13.
REQ-022 A new operand SHALL NOT be accepted in the DONE→IDLE handoff cycle; ready_in goes high the cycle after the handshake.
REQ-023 kill in any state SHALL force IDLE next cycle, drop valid_out, and discard the in-flight result; kill has priority over valid_in and ready_out.
REQ-024 Overflow is impossible (max exp 158); no NV/OF/UF flags are produced.

Reset
REQ-025 On reset: state = IDLE, valid_out = 0, result = 0x00000000, fflag_nx = 0, internal mag/exp/sign cleared.
REQ-026 Reset asserted mid-operation SHALL abort immediately; no valid_out after release until a new accept.

Configuration
REQ-027 Macro FCVT_UNSIGNED_EN defined: is_unsigned honoured per REQ-014.
REQ-028 FCVT_UNSIGNED_EN undefined: is_unsigned ignored; all operands treated as signed.

Structure
REQ-029 Package fcvt_pkg SHALL hold the rounding-mode enum (RNE, RTZ, RDN, RUP, RMM), the FSM state typedef, and constants EXP_BIAS = 127 and EXP_INIT = 158.
REQ-030 Rounding decision and mantissa increment (REQ-016 to REQ-018) SHALL be one combinational sub-module, fcvt_round; the FSM stays in int2float_seq.

Verification
REQ-031 int_in=0x00000001, signed, RNE -> result 0x3F800000, nx 0, valid_out 13 cycles after accept; int_in=0xFFFFFFFF signed -> 0xBF800000.
REQ-032 int_in=0x7FFFFFFF: RNE -> 0x4F000000, nx 1; RTZ -> 0x4EFFFFFF, nx 1.
REQ-033 int_in=0x01000001: RNE tie -> 0x4B800000, nx 1; RUP -> 0x4B800001; RMM -> 0x4B800001.
REQ-034 int_in=0x80000000: signed -> 0xCF000000, nx 0; with FCVT_UNSIGNED_EN and is_unsigned=1 -> 0x4F000000.
REQ-035 int_in=0 -> 0x00000000 after 2 cycles; hold ready_out low 5 cycles -> result and valid_out stable; then handshake -> ready_in high the following cycle.
REQ-036 Assert kill in the 3rd NORM cycle of int_in=1 -> IDLE next cycle, no valid_out; the next operand converts correctly; repeat the scenario with reset instead of kill.
